dpram_stream_reader: RTL
========================

# dpram_stream_reader

Read-side engine for the single-clock dual-port RAM (write-first, one-cycle registered read). On a start command it sweeps `LEN` consecutive RAM addresses from `BASE`, wrapping modulo `DEPTH`, and emits the words as a valid/ready stream with last-beat marking. It absorbs the RAM's read latency and downstream backpressure with a 2-entry output buffer. It is the consumer counterpart to the logic that fills the RAM through its write port.

## Interface
Parameters:
- `WIDTH`, 1: data word width; must match the RAM.
- `DEPTH`, 2: RAM depth; must be at least 2 and a power of two. `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: command strobe; sampled only while IDLE.
- `base_addr`  in  AW: first read address; captured on an accepted start.
- `length`  in  AW+1: number of words, 0..DEPTH; captured on an accepted start.
- `busy`  out  1: a transfer is in progress.
- `done`  out  1: one-cycle pulse at transfer completion.
- `rd_addr`  out  AW: registered; connects to the RAM `rd_addr`.
- `q`  in  WIDTH: RAM read data; valid in the cycle after the cycle in which `rd_addr` was issued.
- `m_tdata`  out  WIDTH: stream data.
- `m_tvalid`  out  1: stream valid.
- `m_tready`  in  1: stream ready.
- `m_tlast`  out  1: marks the final beat of a transfer.

## Operation
- States are IDLE, RUN and DRAIN.
- **IDLE:** `start` high captures `base_addr`/`length`.
  - If `length` is 0, the block stays IDLE and `done` pulses next cycle. No beats are produced.
  - Otherwise the block enters RUN, `rd_addr` is loaded with `base_addr`, and the issue counter is set to `length`.
- **RUN:** each cycle the block evaluates `issue = (remaining != 0) && (occ + inflight - pop) <= 1`.
  - `occ` is the buffer occupancy (0..2), `inflight` is a 1-bit register set on the cycle after an issue, and `pop = m_tvalid & m_tready`.
  - On an issue, `remaining` decrements, `rd_addr` increments (AW-bit wrap, DEPTH-1 → 0), and `inflight` is set for the next cycle.
  - When `inflight` is high, `q` is pushed into the buffer. Its last flag is set if it is the `length`-th word.
  - When `remaining` reaches 0, the block enters DRAIN.
- **DRAIN:** no further issues. When the last-flagged beat is popped, the block returns to IDLE and `done` pulses in the following cycle.
- The buffer is a 2-entry FIFO. The head drives `m_tdata`/`m_tlast`, and `m_tvalid = (occ != 0)`.
- Once `m_tvalid` is asserted, `m_tdata` and `m_tlast` hold stable until the beat is accepted. A push and a pop in the same cycle are legal.
- The buffer never overflows (guaranteed by the issue rule). If a push arrives at a full buffer, a simulation assertion fires.
- `start` while busy is ignored. `start` in the `done` cycle is accepted, because the block is already IDLE.
- `busy` is high in RUN and DRAIN only.
- `rd_addr` holds its last value when not issuing.

## Timing
- **Reset values:** `busy` 0, `done` 0, `m_tvalid` 0, `m_tlast` 0, `m_tdata` 0, `rd_addr` 0. State is IDLE and `occ`, `inflight`, `remaining` are all 0.
- **Mid-transfer reset:** assertion of `rst_n` forces all of the above immediately (asynchronous). Buffered data is discarded and no `done` is produced.
- **Start latency:** with `start` in cycle 0:
  - `busy` and `rd_addr = base` in cycle 1;
  - `q` is valid in cycle 2;
  - first `m_tvalid` in cycle 3.
- **Throughput:** with `m_tready` held high, one beat per cycle. Beat n appears in cycle 3+n and the last beat in cycle 2+`length`.
- **Completion:** `done` is high in the cycle after the last handshake. `busy` goes low in that same cycle.
- **Backpressure:** after `m_tready` deasserts, at most 2 words are buffered and issue stalls. On release, streaming resumes at one beat per cycle with no bubble.
- **Combinational path:** the only combinational path is `m_tready` → issue → the `rd_addr`/`inflight` register inputs.

## Structure
- Shared package `dpram_reader_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the `localparam` buffer depth, set to 2;
  - an address-width helper function.
- One sub-module, `reader_skid_fifo`: a 2-entry, WIDTH+1-bit FIFO (data plus last flag) with push, pop and occupancy, reset asynchronously via `rst_n`.
- The top level holds the FSM, issue counter, address register and `inflight` flag.

## Test plan
- **Basic sweep:** RAM preloaded with `ram[i]=i+0x10` (DEPTH=16). Start with base=3, len=4, `m_tready` high → beats 0x13, 0x14, 0x15, 0x16 in cycles 3–6. `m_tlast` on 0x16, `done` in cycle 7.
- **Wrap-around:** base=14, len=4 → addresses 14, 15, 0, 1. Data 0x1E, 0x1F, 0x10, 0x11.
- **Backpressure:** len=8 with `m_tready` toggling 1,0,0,1,… or held low for 5 cycles mid-burst → all 8 words delivered in order with none lost or duplicated. Data stays stable while stalled and `occ` is never above 2.
- **Edge lengths:**
  - len=0 → `done` the next cycle, `busy` never high, no `m_tvalid`;
  - len=16 from base 5 → all 16 words exactly once.
- **Command handling:**
  - a second `start` while busy is ignored;
  - a `start` in the `done` cycle launches the next transfer in the following cycle.
- **Reset mid-burst:** `rst_n` low after beat 2 of a len=8 transfer → outputs immediately at reset values. A new start after release produces a correct fresh transfer.

Source files
------------

// File: rtl/dpram_stream_reader_pkg.sv
// Shared definitions for the dual-port RAM stream reader.
//   state_t    : reader FSM states
//   BUF_DEPTH  : entries in the output skid buffer
//   addr_width : RAM address width for a given depth (minimum 1 bit)
package dpram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dpram_stream_reader_if.sv
// Valid/ready output stream of the RAM reader.
//   m_tdata  : stream data word
//   m_tvalid : head of the output buffer is valid
//   m_tready : downstream accepts the beat
//   m_tlast  : final beat of a transfer
// master = reader side, slave = consumer side.
interface dpram_stream_reader_if #(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/dpram_stream_reader_skid_fifo.sv
// Two-entry output buffer for the RAM reader (data plus last flag).
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_din this cycle
//   i_din      : {last, data}
//   i_pop      : head consumed this cycle
//   o_head     : head entry, held stable until popped
//   o_occ      : occupancy 0..2
//   o_valid    : occupancy non-zero
module reader_skid_fifo
  import dpram_reader_pkg::*;
#(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [1:0]    o_occ,
  output logic          o_valid
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [DW-1:0] r_slot0;
  logic [DW-1:0] r_slot1;
  logic [1:0]    r_occ;

  // Slot 0 is always the head, so the output never moves while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_occ   <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_slot0 <= i_din;
            r_occ   <= r_occ + 2'd1;
          end else if (r_occ != FULL) begin
            r_slot1 <= i_din;
            r_occ   <= r_occ + 2'd1;
          end
        end
        2'b01: begin
          r_slot0 <= r_slot1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_slot0 <= i_din;
          end else begin
            r_slot0 <= r_slot1;
            r_slot1 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_slot0;
  assign o_occ   = r_occ;
  assign o_valid = (r_occ != 2'd0);

  // The issue rule upstream must never let a push hit a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_pop && (r_occ == FULL)));

endmodule

// File: rtl/dpram_stream_reader.sv
// Read-side engine for a single-clock dual-port RAM with one-cycle read
// latency. Sweeps length words from base_addr (wrapping) and streams them out.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : command strobe, honoured only in IDLE
//   base_addr  : first RAM address
//   length     : word count 0..DEPTH
//   busy       : transfer in progress (RUN or DRAIN)
//   done       : one-cycle completion pulse
//   rd_addr    : registered RAM read address
//   q          : RAM read data, valid the cycle after rd_addr is issued
//   m_axis     : output stream (master modport)
//
// state | meaning
// IDLE  | waiting for start; zero-length start only pulses done
// RUN   | issuing RAM reads while words remain
// DRAIN | all reads issued; waiting for the last beat to be accepted
module dpram_stream_reader
  import dpram_reader_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 2,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         rd_addr,
  input  logic [WIDTH-1:0]      q,
  dpram_stream_reader_if.master m_axis
);

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_inflight;
  logic          r_inflight_last;
  logic [AW-1:0] r_rd_addr;
  logic [AW:0]   r_remaining;

  logic          w_valid;
  logic          w_pop;
  logic          w_issue;
  logic [1:0]    w_occ;
  logic [2:0]    w_level;
  logic [WIDTH:0] w_head;

  assign w_pop = w_valid & m_axis.m_tready;

  // Occupancy the buffer will have once the read in flight lands; a new read
  // is only issued if there is still room for it after that.
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == RUN) && (r_remaining != '0) && (w_level <= 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_rd_addr       <= '0;
      r_remaining     <= '0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remaining == (AW+1)'(1));
      case (r_state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= RUN;
              r_busy      <= 1'b1;
              r_rd_addr   <= base_addr;
              r_remaining <= length;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_remaining <= r_remaining - (AW+1)'(1);
            r_rd_addr   <= r_rd_addr + AW'(1);
            if (r_remaining == (AW+1)'(1)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && w_head[WIDTH]) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  reader_skid_fifo #(
    .DW (WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_din   ({r_inflight_last, q}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_occ   (w_occ),
    .o_valid (w_valid)
  );

  assign busy            = r_busy;
  assign done            = r_done;
  assign rd_addr         = r_rd_addr;
  assign m_axis.m_tdata  = w_head[WIDTH-1:0];
  assign m_axis.m_tlast  = w_head[WIDTH];
  assign m_axis.m_tvalid = w_valid;

endmodule
